// File: rtl/fpu_io_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : fpu_io_pkg
//  Purpose  : Tag codes, error codes and FSM states of the FPU IO front end.
//  Revision : 1.0
// ============================================================================
package fpu_io_pkg;

  localparam int TAG_W_DEF = 2;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  localparam tag_t TAG_IDLE = 2'd0;
  localparam tag_t TAG_RES  = 2'd1;
  localparam tag_t TAG_FLG  = 2'd2;
  localparam tag_t TAG_CMD  = 2'd3;

  localparam logic [7:0] ERR_NOT_LOADED = 8'h01;
  localparam logic [7:0] ERR_BUSY       = 8'h02;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    FLAGS = 3'd4
  } state_t;

  function automatic int beats_per_op(input int op_w, input int beat_w);
    return op_w / beat_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_tagged_io_frontend_if.sv
`default_nettype none
// ============================================================================
//  Interface : fpu_tagged_io_frontend_if
//  Purpose   : Tagged beat IO pins plus the command/result channel to the core.
//  Revision  : 1.0
// ============================================================================
interface fpu_tagged_io_frontend_if
  import fpu_io_pkg::*;
#(
  parameter int OP_W    = 16,
  parameter int BEAT_W  = 8,
  parameter int NUM_SRC = 2,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int CMD_W   = 4,
  parameter int FLAG_W  = 5
);

  logic [BEAT_W-1:0]       in_val;
  logic [TAG_W-1:0]        in_tag;
  logic [BEAT_W-1:0]       out_val;
  logic [TAG_W-1:0]        out_tag;
  logic                    core_valid;
  logic                    core_ready;
  logic [CMD_W-1:0]        core_cmd;
  logic [NUM_SRC*OP_W-1:0] core_src;
  logic                    core_res_valid;
  logic [OP_W-1:0]         core_res;
  logic [FLAG_W-1:0]       core_flags;
  logic                    busy;

  // Front end side
  modport slave (
    input  in_val, in_tag, core_ready, core_res_valid, core_res, core_flags,
    output out_val, out_tag, core_valid, core_cmd, core_src, busy
  );

  // Pin driver / core side
  modport master (
    output in_val, in_tag, core_ready, core_res_valid, core_res, core_flags,
    input  out_val, out_tag, core_valid, core_cmd, core_src, busy
  );

endinterface
`default_nettype wire

// File: rtl/fpu_beat_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_beat_shifter
//  Purpose  : One operand slot assembled MS-beat-first, with beat count and full bit.
//  Revision : 1.0
// ============================================================================
module fpu_beat_shifter
  import fpu_io_pkg::*;
#(
  parameter int OP_W   = 16,
  parameter int BEAT_W = 8
)(
  input  wire               clk,
  input  wire               rst,
  input  wire               i_wr,
  input  wire  [BEAT_W-1:0] i_beat,
  input  wire               i_clr,
  output logic [OP_W-1:0]   o_data,
  output logic              o_full
);

  localparam int BEATS = beats_per_op(OP_W, BEAT_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [OP_W-1:0]  r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic [CNT_W-1:0] w_cnt_base;

  // A clear in the same cycle as a write makes that write the first beat.
  always_comb begin
    w_cnt_base = r_cnt;
    if (i_clr || r_full) begin
      w_cnt_base = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_data <= (r_data << BEAT_W) | OP_W'(i_beat);
      if (w_cnt_base == CNT_W'(BEATS - 1)) begin
        r_full <= 1'b1;
        r_cnt  <= '0;
      end else begin
        r_full <= 1'b0;
        r_cnt  <= w_cnt_base + CNT_W'(1);
      end
    end else if (i_clr) begin
      r_full <= 1'b0;
      r_cnt  <= '0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/fpu_tagged_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_tagged_io_frontend
//  Purpose  : Tagged byte-serial operand loader, command issuer and result serialiser.
//  Revision : 1.0
// ============================================================================
module fpu_tagged_io_frontend
  import fpu_io_pkg::*;
#(
  parameter int OP_W    = 16,
  parameter int BEAT_W  = 8,
  parameter int NUM_SRC = 2,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int CMD_W   = 4,
  parameter int FLAG_W  = 5
)(
  input wire clock,
  input wire reset,
  fpu_tagged_io_frontend_if.slave bus
);

  localparam int BEATS = beats_per_op(OP_W, BEAT_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [TAG_W-1:0] c_TAG_IDLE = TAG_W'(TAG_IDLE);
  localparam logic [TAG_W-1:0] c_TAG_RES  = TAG_W'(TAG_RES);
  localparam logic [TAG_W-1:0] c_TAG_FLG  = TAG_W'(TAG_FLG);
  localparam logic [TAG_W-1:0] c_TAG_CMD  = {TAG_W{1'b1}};

  logic [NUM_SRC*OP_W-1:0] w_src;
  logic [NUM_SRC-1:0]      w_full;
  logic                    w_clr;
  logic                    w_cmd_edge;
  logic [TAG_W-1:0]        w_out_tag;
  logic [BEAT_W-1:0]       w_out_val;

  state_t                  r_state;
  logic [TAG_W-1:0]        r_prev_tag;
  logic [CMD_W-1:0]        r_cmd;
  logic [NUM_SRC*OP_W-1:0] r_src;
  logic [OP_W-1:0]         r_res;
  logic [FLAG_W-1:0]       r_flags;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic                    r_err_valid;
  logic [BEAT_W-1:0]       r_err_code;

  assign w_clr      = (r_state == ISSUE) && bus.core_ready;
  assign w_cmd_edge = (bus.in_tag == c_TAG_CMD) && (r_prev_tag != c_TAG_CMD);

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
      fpu_beat_shifter #(
        .OP_W   (OP_W),
        .BEAT_W (BEAT_W)
      ) u_slot (
        .clk    (clock),
        .rst    (reset),
        .i_wr   (bus.in_tag == TAG_W'(k + 1)),
        .i_beat (bus.in_val),
        .i_clr  (w_clr),
        .o_data (w_src[k*OP_W +: OP_W]),
        .o_full (w_full[k])
      );
    end
  endgenerate

  // An error beat stalls SEND/FLAGS by one cycle so no result beat is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prev_tag  <= c_TAG_CMD;
      r_cmd       <= '0;
      r_src       <= '0;
      r_res       <= '0;
      r_flags     <= '0;
      r_beat_cnt  <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_prev_tag  <= bus.in_tag;
      r_err_valid <= 1'b0;
      if (w_cmd_edge) begin
        if (r_state != IDLE) begin
          r_err_valid <= 1'b1;
          r_err_code  <= BEAT_W'(ERR_BUSY);
        end else if (!(&w_full)) begin
          r_err_valid <= 1'b1;
          r_err_code  <= BEAT_W'(ERR_NOT_LOADED);
        end
      end

      case (r_state)
        IDLE: begin
          if (w_cmd_edge && (&w_full)) begin
            r_cmd   <= bus.in_val[CMD_W-1:0];
            r_src   <= w_src;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.core_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.core_res_valid) begin
            r_res      <= bus.core_res;
            r_flags    <= bus.core_flags;
            r_beat_cnt <= '0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (!r_err_valid) begin
            r_res <= r_res << BEAT_W;
            if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
              r_state <= FLAGS;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        FLAGS: begin
          if (!r_err_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_out_tag = c_TAG_IDLE;
    w_out_val = '0;
    if (r_err_valid) begin
      w_out_tag = c_TAG_CMD;
      w_out_val = r_err_code;
    end else if (r_state == SEND) begin
      w_out_tag = c_TAG_RES;
      w_out_val = r_res[OP_W-1 -: BEAT_W];
    end else if (r_state == FLAGS) begin
      w_out_tag = c_TAG_FLG;
      w_out_val = BEAT_W'(r_flags);
    end
  end

  assign bus.out_tag    = w_out_tag;
  assign bus.out_val    = w_out_val;
  assign bus.core_valid = (r_state == ISSUE);
  assign bus.core_cmd   = r_cmd;
  assign bus.core_src   = r_src;
  assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_tagged_io_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_tagged_io_frontend
//  Purpose  : Directed and randomised self-checking bench for the FPU IO front end.
//  Revision : 1.0
// ============================================================================
module tb_fpu_tagged_io_frontend;

  localparam int OP_W = 16, BEAT_W = 8, NUM_SRC = 2, TAG_W = 2, CMD_W = 4, FLAG_W = 5;
  localparam int BEATS = OP_W / BEAT_W;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference slots: value seen on the pins and beats received since (re)start
  logic [OP_W-1:0] mdl_val [NUM_SRC];
  int              mdl_cnt [NUM_SRC];

  always #5 clk = ~clk;

  fpu_tagged_io_frontend_if #(
    .OP_W(OP_W), .BEAT_W(BEAT_W), .NUM_SRC(NUM_SRC),
    .TAG_W(TAG_W), .CMD_W(CMD_W), .FLAG_W(FLAG_W)
  ) bus ();

  fpu_tagged_io_frontend #(
    .OP_W(OP_W), .BEAT_W(BEAT_W), .NUM_SRC(NUM_SRC),
    .TAG_W(TAG_W), .CMD_W(CMD_W), .FLAG_W(FLAG_W)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [1:0] tg, input logic [7:0] v);
    chk({nm, "_tag"}, bus.out_tag, tg);
    chk({nm, "_val"}, bus.out_val, v);
  endtask

  function automatic bit mdl_full(input int s);
    return mdl_cnt[s] == BEATS;
  endfunction

  task automatic mdl_clear_all(input bit wipe);
    for (int s = 0; s < NUM_SRC; s++) begin
      mdl_cnt[s] = 0;
      if (wipe) mdl_val[s] = '0;
    end
  endtask

  task automatic beat(input int slot, input logic [7:0] v);
    bus.in_tag = 2'(slot);
    bus.in_val = v;
    step();
    mdl_val[slot-1] = (mdl_val[slot-1] * 256) + 16'(v);
    mdl_cnt[slot-1] = mdl_full(slot-1) ? 1 : mdl_cnt[slot-1] + 1;
    bus.in_tag = '0;
    bus.in_val = '0;
  endtask

  task automatic load(input int slot, input logic [15:0] v);
    beat(slot, v[15:8]);
    beat(slot, v[7:0]);
  endtask

  task automatic cmd_pulse(input logic [7:0] v);
    bus.in_tag = '0;
    step();
    bus.in_tag = 2'b11;
    bus.in_val = v;
    step();
    bus.in_tag = '0;
    bus.in_val = '0;
  endtask

  task automatic issue(input logic [7:0] cv, input int dly, input string nm);
    logic [31:0] exp_src;
    exp_src = {mdl_val[1], mdl_val[0]};
    cmd_pulse(cv);
    for (int i = 0; i <= dly; i++) begin
      chk({nm, "_valid"}, bus.core_valid, 1'b1);
      chk({nm, "_cmd"}, bus.core_cmd, cv[3:0]);
      chk({nm, "_src"}, bus.core_src, exp_src);
      bus.core_ready = (i == dly);
      step();
    end
    bus.core_ready = 1'b0;
    chk({nm, "_valid_drop"}, bus.core_valid, 1'b0);
    chk({nm, "_busy_wait"}, bus.busy, 1'b1);
    mdl_clear_all(1'b0);
  endtask

  task automatic result(input logic [15:0] rv, input logic [4:0] fv, input int dly, input string nm);
    for (int i = 0; i < dly; i++) begin
      step();
      chk({nm, "_wait_quiet"}, bus.out_tag, 2'b00);
    end
    bus.core_res_valid = 1'b1;
    bus.core_res       = rv;
    bus.core_flags     = fv;
    step();
    bus.core_res_valid = 1'b0;
    bus.core_res       = 16'hDEAD;
    bus.core_flags     = 5'h1F;
    for (int b = 0; b < BEATS; b++) begin
      chk_out({nm, "_res"}, 2'b01, 8'(rv >> (8 * (BEATS - 1 - b))));
      step();
    end
    chk_out({nm, "_flags"}, 2'b10, 8'(fv));
    step();
    chk_out({nm, "_end"}, 2'b00, 8'h00);
    chk({nm, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_valid;
    rst = 1'b1;
    bus.in_tag = 2'b11;
    bus.in_val = 8'h02;
    bus.core_ready = 1'b0;
    bus.core_res_valid = 1'b0;
    bus.core_res = '0;
    bus.core_flags = '0;
    mdl_clear_all(1'b1);
    step(); step(); step();
    chk_out("reset", 2'b00, 8'h00);
    chk("reset_valid", bus.core_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_src", bus.core_src, 32'h0);
    chk("reset_cmd", bus.core_cmd, 4'h0);

    // Command tag held across reset release must not fire
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_valid", bus.core_valid, 1'b0);
      chk("hold_no_err", bus.out_tag, 2'b00);
    end
    bus.in_tag = '0;

    // Happy path, command tag held four cycles
    load(1, 16'h4E54);
    load(2, 16'h4E54);
    bus.core_ready = 1'b1;
    bus.in_tag = 2'b11;
    bus.in_val = 8'h02;
    step();
    chk("happy_valid", bus.core_valid, 1'b1);
    chk("happy_cmd", bus.core_cmd, 4'h2);
    chk("happy_src", bus.core_src, 32'h4E544E54);
    cnt_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.core_valid) cnt_valid++;
      chk("happy_no_err", bus.out_tag, 2'b00);
    end
    chk("happy_one_cmd", 64'(cnt_valid), 64'd1);
    bus.in_tag = '0;
    bus.core_ready = 1'b0;
    mdl_clear_all(1'b0);
    result(16'h0000, 5'h00, 0, "happy");

    // Result pulse outside WAIT is ignored
    bus.core_res_valid = 1'b1;
    bus.core_res = 16'h1234;
    step();
    bus.core_res_valid = 1'b0;
    step();
    chk_out("stray_res", 2'b00, 8'h00);
    chk("stray_busy", bus.busy, 1'b0);

    // Partial load
    load(1, 16'h1234);
    beat(2, 8'h3C);
    cmd_pulse(8'h02);
    chk_out("partial_err", 2'b11, 8'h01);
    chk("partial_valid", bus.core_valid, 1'b0);
    chk("partial_busy", bus.busy, 1'b0);
    step();
    chk_out("partial_end", 2'b00, 8'h00);
    chk("partial_busy2", bus.busy, 1'b0);

    // Backpressure
    beat(2, 8'h00);
    issue(8'h05, 3, "bp");
    result(16'h1357, 5'h1F, 2, "bp");

    // Busy command during WAIT, reload during WAIT, error pre-empting SEND
    load(1, 16'hAAAA);
    load(2, 16'h5555);
    issue(8'h06, 0, "busy");
    cmd_pulse(8'h07);
    chk_out("busy_err", 2'b11, 8'h02);
    step();
    chk_out("busy_err_end", 2'b00, 8'h00);
    load(1, 16'h3C00);
    load(2, 16'h4000);
    chk("reload_busy", bus.busy, 1'b1);
    bus.core_res_valid = 1'b1;
    bus.core_res = 16'hABCD;
    bus.core_flags = 5'h15;
    step();
    bus.core_res_valid = 1'b0;
    chk_out("pre_res0", 2'b01, 8'hAB);
    bus.in_tag = 2'b11;
    bus.in_val = 8'h09;
    step();
    bus.in_tag = '0;
    chk_out("pre_err", 2'b11, 8'h02);
    step();
    chk_out("pre_res1", 2'b01, 8'hCD);
    step();
    chk_out("pre_flags", 2'b10, 8'h15);
    step();
    chk_out("pre_end", 2'b00, 8'h00);
    chk("pre_idle", bus.busy, 1'b0);
    issue(8'h01, 0, "reload");
    chk("reload_src", bus.core_src, 32'h40003C00);
    result(16'h8001, 5'h03, 1, "reload");

    // Slot restart after a write to a full slot
    beat(1, 8'h12);
    beat(1, 8'h34);
    beat(1, 8'h56);
    load(2, 16'h1111);
    cmd_pulse(8'h03);
    chk_out("restart_notfull", 2'b11, 8'h01);
    beat(1, 8'h78);
    issue(8'h08, 1, "restart");
    chk("restart_slot", bus.core_src[15:0], 16'h5678);
    result(16'h0F0F, 5'h0A, 0, "restart");

    // Reset during SEND with command tag held
    load(1, 16'h2222);
    load(2, 16'h3333);
    issue(8'h04, 0, "rst");
    bus.core_res_valid = 1'b1;
    bus.core_res = 16'h9999;
    step();
    bus.core_res_valid = 1'b0;
    chk_out("rst_send", 2'b01, 8'h99);
    rst = 1'b1;
    bus.in_tag = 2'b11;
    bus.in_val = 8'h04;
    step();
    chk_out("rst_out", 2'b00, 8'h00);
    chk("rst_valid", bus.core_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    mdl_clear_all(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold_valid", bus.core_valid, 1'b0);
      chk("rst_hold_out", bus.out_tag, 2'b00);
    end
    bus.in_tag = '0;
    cmd_pulse(8'h04);
    chk_out("rst_empty", 2'b11, 8'h01);
    chk("rst_src", bus.core_src, 32'h0);

    // Randomised transactions
    for (int it = 0; it < 24; it++) begin
      logic [7:0]  cv;
      int          nb;
      for (int s = 1; s <= NUM_SRC; s++) begin
        nb = int'($urandom_range(2, 3));
        for (int j = 0; j < nb; j++) begin
          beat(s, 8'($urandom));
          if ($urandom_range(0, 1) == 1) step();
        end
      end
      cv = 8'($urandom);
      if (!(mdl_full(0) && mdl_full(1))) begin
        cmd_pulse(cv);
        chk_out("rnd_notfull", 2'b11, 8'h01);
        chk("rnd_notfull_valid", bus.core_valid, 1'b0);
        for (int s = 0; s < NUM_SRC; s++) begin
          if (!mdl_full(s)) beat(s + 1, 8'($urandom));
        end
      end
      issue(cv, int'($urandom_range(0, 3)), "rnd");
      result(16'($urandom), 5'($urandom), int'($urandom_range(0, 3)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
